// File: rtl/div_seq_ctrl.sv
// Sequencing controller for a restoring divider: one quotient bit per SHIFT/CMP pair, MSB first.
// Optional signed operation is enabled with `define DIV_SIGNED_EN.
module div_seq_ctrl #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic         div_zero,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         load_en,
  output logic         shift_en,
  output logic         sub_en
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CMP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [N-1:0]  dvd_q, dvd_d;
  logic [N-1:0]  dsr_q, dsr_d;
  logic [N:0]    rem_q, rem_d;
  logic [N-1:0]  q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rmd_q, rmd_d;
  logic          dz_q, dz_d;

  logic          sub_take;
  logic          dvd_bit;
  logic [N-1:0]  dvd_sh;
  logic [N-1:0]  bit_mask;

`ifdef DIV_SIGNED_EN
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
`endif

  always_comb begin
    sub_take = (rem_q >= {1'b0, dsr_q});
    dvd_sh   = dvd_q >> cnt_q;
    dvd_bit  = dvd_sh[0];
    bit_mask = {{(N-1){1'b0}}, 1'b1} << cnt_q;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (divisor == '0) ? S_DONE : S_SHIFT;
      S_SHIFT: state_d = S_CMP;
      S_CMP:   state_d = (cnt_q == '0) ? S_DONE : S_SHIFT;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    shift_en = (state_q == S_SHIFT);
    load_en  = (state_q == S_SHIFT) && (cnt_q == CW'(N-1));
    sub_en   = (state_q == S_CMP) && sub_take;
  end

  // Datapath next values; result registers load only on the transition into DONE
  always_comb begin
    dvd_d = dvd_q;
    dsr_d = dsr_q;
    rem_d = rem_q;
    q_d   = q_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rmd_d = rmd_q;
    dz_d  = dz_q;
`ifdef DIV_SIGNED_EN
    qneg_d = qneg_q;
    rneg_d = rneg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef DIV_SIGNED_EN
          dvd_d  = dividend[N-1] ? -dividend : dividend;
          dsr_d  = divisor[N-1]  ? -divisor  : divisor;
          qneg_d = dividend[N-1] ^ divisor[N-1];
          rneg_d = dividend[N-1];
`else
          dvd_d = dividend;
          dsr_d = divisor;
`endif
          rem_d = '0;
          q_d   = '0;
          cnt_d = CW'(N-1);
          if (divisor == '0) begin
            quo_d = '1;
            rmd_d = dividend;
            dz_d  = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        rem_d = {rem_q[N-1:0], dvd_bit};
      end
      S_CMP: begin
        if (sub_take) begin
          rem_d = rem_q - {1'b0, dsr_q};
          q_d   = q_q | bit_mask;
        end else begin
          q_d   = q_q & ~bit_mask;
        end
        if (cnt_q == '0) begin
`ifdef DIV_SIGNED_EN
          quo_d = qneg_q ? -q_d : q_d;
          rmd_d = rneg_q ? -rem_d[N-1:0] : rem_d[N-1:0];
`else
          quo_d = q_d;
          rmd_d = rem_d[N-1:0];
`endif
          dz_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvd_q <= '0;
      dsr_q <= '0;
      rem_q <= '0;
      q_q   <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rmd_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      dvd_q <= dvd_d;
      dsr_q <= dsr_d;
      rem_q <= rem_d;
      q_q   <= q_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rmd_q <= rmd_d;
      dz_q  <= dz_d;
    end
  end

`ifdef DIV_SIGNED_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end
`endif

  assign quotient  = quo_q;
  assign remainder = rmd_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: driver pushes expected results, negedge monitor pops and checks.
module tb_div_seq_ctrl;
  localparam int N  = 8;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy, done, div_zero, load_en, shift_en, sub_en;
  logic [N-1:0] quotient, remainder;

  div_seq_ctrl #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .div_zero(div_zero), .quotient(quotient),
    .remainder(remainder), .load_en(load_en), .shift_en(shift_en), .sub_en(sub_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    int           acc;
    int           subs;
  } exp_t;

  exp_t sbq[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_shift = 0, n_sub = 0, n_load = 0;
  logic [N-1:0] held_q = '0, held_r = '0;
  logic held_dz = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division on magnitudes, signs applied afterwards
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    int sa, sb, ma, mb, qm, rm;
`ifdef DIV_SIGNED_EN
    sa = int'($signed(a));
    sb = int'($signed(b));
`else
    sa = int'({24'd0, a});
    sb = int'({24'd0, b});
`endif
    e.acc = 0;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1; e.subs = 0;
    end else begin
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      qm = (ma / mb) & 255;
      rm = ma % mb;
      e.subs = $countones(qm);
      e.q = N'(((sa < 0) != (sb < 0)) ? -qm : qm);
      e.r = N'((sa < 0) ? -rm : rm);
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      n_shift = 0; n_sub = 0; n_load = 0;
      held_q = '0; held_r = '0; held_dz = 1'b0;
    end else begin
      if (shift_en) n_shift++;
      if (sub_en)   n_sub++;
      if (load_en)  n_load++;
      if (done) begin
        if (sbq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
        end else begin
          e = sbq.pop_front();
          check("quotient", 32'(quotient), 32'(e.q));
          check("remainder", 32'(remainder), 32'(e.r));
          check("div_zero", 32'(div_zero), 32'(e.dz));
          check("latency", 32'(cyc - e.acc), e.dz ? 32'd1 : 32'(2*N+1));
          check("shift_cnt", 32'(n_shift), e.dz ? 32'd0 : 32'(N));
          check("load_cnt", 32'(n_load), e.dz ? 32'd0 : 32'd1);
          check("sub_cnt", 32'(n_sub), 32'(e.subs));
          held_q = e.q; held_r = e.r; held_dz = e.dz;
        end
        n_shift = 0; n_sub = 0; n_load = 0;
      end else begin
        check("hold_q", 32'(quotient), 32'(held_q));
        check("hold_r", 32'(remainder), 32'(held_r));
        check("hold_dz", 32'(div_zero), 32'(held_dz));
      end
    end
  end

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    int g = 0;
    @(negedge clk);
    while (busy && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (busy) begin
      tests++; fails++;
      $display("FAIL idle_timeout: got busy=1 expected 0");
    end
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e = model(a, b);
    e.acc = cyc;
    sbq.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    dividend = N'($urandom);
    divisor  = N'($urandom);
  endtask

  task automatic wait_done();
    int g = 0;
    while (sbq.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (sbq.size() != 0) begin
      tests++; fails++;
      $display("FAIL done_timeout: got %0d pending expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic run(input logic [N-1:0] a, input logic [N-1:0] b);
    issue(a, b);
    wait_done();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_dz", 32'(div_zero), 32'd0);
    check("rst_strobes", {29'd0, load_en, shift_en, sub_en}, 32'd0);
    rst = 1'b1;

    run(8'd100, 8'd7);
    run(8'd5, 8'd0);
    run(8'd255, 8'd1);
    run(8'd3, 8'd200);
    run(8'd0, 8'd5);
    run(8'd255, 8'd255);

    // Start pulses while busy must be ignored
    issue(8'd100, 8'd7);
    repeat (3) @(negedge clk);
    dividend = 8'd9; divisor = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    run(8'd9, 8'd3);

    // Asynchronous abort mid-operation
    issue(8'd200, 8'd9);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_q", 32'(quotient), 32'd0);
    check("abort_r", 32'(remainder), 32'd0);
    check("abort_strobes", {29'd0, load_en, shift_en, sub_en}, 32'd0);
    sbq.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    run(8'd200, 8'd9);

    run(8'h9C, 8'd7);
    run(8'd100, 8'hF9);
    run(8'h80, 8'hFF);
    run(8'h80, 8'h00);

    for (int i = 0; i < 60; i++) begin
      logic [N-1:0] a, b;
      a = N'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      run(a, b);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
